// File: rtl/sram_arb_pkg.sv
// Shared types and default sizing for the two-requester SRAM arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package sram_arb_pkg;

  // Default geometry: 1K words of 32 bits, 4-beat bursts.
  localparam int AW_DEF        = 10;
  localparam int DW_DEF        = 32;
  localparam int BURST_LEN_DEF = 4;

  // Bus owner state machine. TURN is the single dead cycle between owners.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    TURN = 2'd2
  } state_t;

  // Attributes of the transaction in flight, latched at grant.
  typedef struct packed {
    logic owner;  // 0 = requester 0, 1 = requester 1
    logic we;     // 1 = write, 0 = read
    logic burst;  // 1 = BURST_LEN beats, 0 = single beat
  } txn_t;

  // Beat counter width. It never drops to zero, so single-beat builds still get a legal vector.
  function automatic int beat_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sram_arb_rr.sv
// Two-way grant selector with a last-grant pointer.
// Latency: sel is combinational from req; the pointer updates on the grant edge.
// Backpressure: none; sel is only consumed when the arbiter can grant (take high).
// Build option: SRAM_ARB_RR_EN selects round-robin, otherwise requester 0 has fixed priority.
module sram_arb_rr
  import sram_arb_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic req0,
  input  logic req1,
  input  logic take,
  output logic sel
);

  logic last;

  // Pick the winner. With no request, sel rests on the last owner.
  always_comb begin
    sel = last;
`ifdef SRAM_ARB_RR_EN
    if (req0 && req1) begin
      sel = ~last;
    end else if (req0) begin
      sel = 1'b0;
    end else if (req1) begin
      sel = 1'b1;
    end
`else
    if (req0) begin
      sel = 1'b0;
    end else if (req1) begin
      sel = 1'b1;
    end
`endif
  end

  // Remember who was granted last. Reset points at requester 1, so requester 0 wins first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last <= 1'b1;
    end else if (take) begin
      last <= sel;
    end
  end

endmodule

// File: rtl/sram_arb.sv
// Arbitrates two requesters onto one async-strobed SRAM, with single-beat or BURST_LEN-beat transfers.
// Latency: beat 0 is in the cycle after req is sampled; read data and rvalid follow each read beat by one cycle.
// Backpressure: a requester holds req until its final ack. The loser waits, and every ownership change costs one TURN cycle.
// Build option: SRAM_ARB_RR_EN enables round-robin arbitration (fixed priority to requester 0 when undefined).
module sram_arb
  import sram_arb_pkg::*;
#(
  parameter int AW        = AW_DEF,
  parameter int DW        = DW_DEF,
  parameter int BURST_LEN = BURST_LEN_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic          req1,
  input  logic          we0,
  input  logic          we1,
  input  logic          burst0,
  input  logic          burst1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdat0,
  input  logic [DW-1:0] wdat1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          ack0,
  output logic          ack1,
  output logic          rvalid0,
  output logic          rvalid1,
  output logic [DW-1:0] rdat,
  output logic [AW-1:0] addr,
  output logic          rd_,
  output logic          wr_,
  inout  wire  [DW-1:0] dat
);

  localparam int            BW        = beat_bits(BURST_LEN);
  localparam logic [BW-1:0] LAST_BEAT = BW'(BURST_LEN - 1);

  state_t        state;
  txn_t          cur;
  logic [BW-1:0] beat;

  logic sel;
  logic any_req;
  logic take;
  logic last_beat;
  logic sel_we;
  logic dat_oe;
  logic rd_beat;

  assign any_req = req0 | req1;

  // A new owner can be chosen only between transactions. The choice lands in registers on this edge.
  assign take = any_req & ((state == IDLE) | (state == TURN));

  // Direction of the winning request, sampled together with req at grant.
  assign sel_we = sel ? we1 : we0;

  // Single-beat transfers end after beat 0. Bursts end on the final beat index.
  assign last_beat = cur.burst ? (beat == LAST_BEAT) : 1'b1;

  // Only a write beat drives the shared bus. wr_ is a register, so the driver cannot glitch.
  assign dat_oe = ~wr_;
  assign dat    = dat_oe ? (cur.owner ? wdat1 : wdat0) : {DW{1'bz}};

  // A read beat is any XFER cycle owned by a read transaction.
  assign rd_beat = (gnt0 | gnt1) & ~cur.we;

  sram_arb_rr u_rr (
    .clk  (clk),
    .rst  (rst),
    .req0 (req0),
    .req1 (req1),
    .take (take),
    .sel  (sel)
  );

  // Owner FSM: grant, step through the beats, then give up the bus for one turnaround cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cur   <= '0;
      beat  <= '0;
      gnt0  <= 1'b0;
      gnt1  <= 1'b0;
      ack0  <= 1'b0;
      ack1  <= 1'b0;
      rd_   <= 1'b1;
      wr_   <= 1'b1;
      addr  <= '0;
    end else begin
      case (state)
        IDLE, TURN: begin
          if (any_req) begin
            state     <= XFER;
            cur.owner <= sel;
            cur.we    <= sel_we;
            cur.burst <= sel ? burst1 : burst0;
            beat      <= '0;
            addr      <= sel ? addr1 : addr0;
            gnt0      <= ~sel;
            gnt1      <= sel;
            ack0      <= ~sel;
            ack1      <= sel;
            rd_       <= sel_we;
            wr_       <= ~sel_we;
          end else begin
            state <= IDLE;
          end
        end
        XFER: begin
          // req is ignored here: once granted, a burst always runs to completion.
          if (last_beat) begin
            state <= TURN;
            gnt0  <= 1'b0;
            gnt1  <= 1'b0;
            ack0  <= 1'b0;
            ack1  <= 1'b0;
            rd_   <= 1'b1;
            wr_   <= 1'b1;
          end else begin
            beat <= beat + 1'b1;
            addr <= addr + 1'b1;  // wraps modulo 2^AW
          end
        end
        default: begin
          state <= IDLE;
          gnt0  <= 1'b0;
          gnt1  <= 1'b0;
          ack0  <= 1'b0;
          ack1  <= 1'b0;
          rd_   <= 1'b1;
          wr_   <= 1'b1;
        end
      endcase
    end
  end

  // Capture SRAM data at the edge that ends each read beat. It is presented to the owner on the next cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdat    <= '0;
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
    end else begin
      rvalid0 <= gnt0 & ~cur.we;
      rvalid1 <= gnt1 & ~cur.we;
      if (rd_beat) begin
        rdat <= dat;
      end
    end
  end

endmodule

// File: tb/tb_sram_arb.sv
// Directed bench for sram_arb, with a behavioural async SRAM on the shared bus.
// Latency: n/a.
// Backpressure: n/a.
module tb_sram_arb;

`ifdef SRAM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
  logic        burst0 = 1'b0, burst1 = 1'b0;
  logic [9:0]  addr0 = '0, addr1 = '0;
  logic [31:0] wdat0 = '0, wdat1 = '0;
  logic        gnt0, gnt1, ack0, ack1, rvalid0, rvalid1, rd_, wr_;
  logic [31:0] rdat;
  logic [9:0]  addr;
  wire  [31:0] dat;

  logic [31:0] mem [0:1023];

  int checks = 0;
  int errors = 0;

  // Observations of the last transaction run through run_txn.
  int          nack, nrv, nwr, nother;
  logic [9:0]  beat_addr [4];
  logic [31:0] rv_dat [4];
  bit          turn_ok;

  sram_arb dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .burst0(burst0), .burst1(burst1), .addr0(addr0), .addr1(addr1),
    .wdat0(wdat0), .wdat1(wdat1),
    .gnt0(gnt0), .gnt1(gnt1), .ack0(ack0), .ack1(ack1),
    .rvalid0(rvalid0), .rvalid1(rvalid1), .rdat(rdat),
    .addr(addr), .rd_(rd_), .wr_(wr_), .dat(dat)
  );

  always #5 clk = ~clk;

  // Async SRAM: it drives the bus while rd_ is low and writes on the clock edge that ends a write beat.
  assign dat = (!rd_) ? mem[addr] : 32'bz;
  always @(posedge clk) if (!wr_) mem[addr] <= dat;

  // Bus invariants, checked every cycle outside reset.
  always @(negedge clk) begin
    if (!rst) begin
      assert (rd_ || wr_) else begin
        errors++;
        $display("FAIL strobe_overlap rd_=%b wr_=%b want never both 0", rd_, wr_);
      end
      assert (!(gnt0 && gnt1)) else begin
        errors++;
        $display("FAIL gnt_overlap gnt0=%b gnt1=%b want never both 1", gnt0, gnt1);
      end
    end
  end

  task automatic drive(input bit r, input bit q, input bit we, input bit b,
                       input logic [9:0] a, input logic [31:0] d);
    if (r) begin req1 = q; we1 = we; burst1 = b; addr1 = a; wdat1 = d; end
    else   begin req0 = q; we0 = we; burst0 = b; addr0 = a; wdat0 = d; end
  endtask

  task automatic sample(input bit r, output bit hit);
    hit = r ? ack1 : ack0;
    if (hit) begin
      if (nack < 4) beat_addr[nack] = addr;
      nack++;
    end
    if (r ? ack0 : ack1) nother++;
    if (r ? rvalid1 : rvalid0) begin
      if (nrv < 4) rv_dat[nrv] = rdat;
      nrv++;
    end
    if (!wr_) nwr++;
  endtask

  // Run one transaction, recording the beats. The final sample is taken in the cycle after the last beat (TURN).
  task automatic run_txn(input bit r, input bit we, input bit b,
                         input logic [9:0] a, input logic [31:0] wbase);
    int nb;
    bit hit;
    nb = b ? 4 : 1;
    nack = 0; nrv = 0; nwr = 0; nother = 0;
    for (int k = 0; k < 4; k++) begin beat_addr[k] = 'x; rv_dat[k] = 'x; end
    drive(r, 1'b1, we, b, a, wbase);
    for (int c = 0; c < 20 && nack < nb; c++) begin
      @(negedge clk);
      sample(r, hit);
      if (hit && nack < nb) begin
        @(posedge clk); #1;
        if (r) wdat1 = wbase + 32'(nack); else wdat0 = wbase + 32'(nack);
      end
    end
    if (r) req1 = 1'b0; else req0 = 1'b0;
    @(negedge clk);
    sample(r, hit);
    turn_ok = rd_ && wr_ && !gnt0 && !gnt1 && !dut.dat_oe;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if ({gnt0, gnt1, ack0, ack1, rvalid0, rvalid1} !== 6'b0) begin errors++;
      $display("FAIL reset_flags got %b want 000000", {gnt0, gnt1, ack0, ack1, rvalid0, rvalid1}); end
    checks++; if ({rd_, wr_} !== 2'b11) begin errors++;
      $display("FAIL reset_strobes got %b want 11", {rd_, wr_}); end
    checks++; if (addr !== 10'h000) begin errors++;
      $display("FAIL reset_addr got %h want 000", addr); end
    checks++; if (rdat !== 32'h0) begin errors++;
      $display("FAIL reset_rdat got %h want 0", rdat); end
    checks++; if (dut.dat_oe !== 1'b0) begin errors++;
      $display("FAIL reset_dat_oe got %b want 0", dut.dat_oe); end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if ({gnt0, gnt1, rd_, wr_} !== 4'b0011) begin errors++;
      $display("FAIL idle_after_reset got %b want 0011", {gnt0, gnt1, rd_, wr_}); end
  endtask

  task automatic test_single;
    run_txn(1'b0, 1'b1, 1'b0, 10'h100, 32'hAA);
    checks++; if (nack !== 1) begin errors++; $display("FAIL single_wr_acks got %0d want 1", nack); end
    checks++; if (beat_addr[0] !== 10'h100) begin errors++; $display("FAIL single_wr_addr got %h want 100", beat_addr[0]); end
    checks++; if (nwr !== 1) begin errors++; $display("FAIL single_wr_strobe_cycles got %0d want 1", nwr); end
    checks++; if (nother !== 0 || nrv !== 0) begin errors++; $display("FAIL single_wr_stray got ack1=%0d rv=%0d want 0 0", nother, nrv); end
    checks++; if (!turn_ok) begin errors++; $display("FAIL single_wr_turn got 0 want 1"); end
    run_txn(1'b0, 1'b0, 1'b0, 10'h100, 32'h0);
    checks++; if (nack !== 1) begin errors++; $display("FAIL single_rd_acks got %0d want 1", nack); end
    checks++; if (nrv !== 1) begin errors++; $display("FAIL single_rd_rvalid got %0d want 1", nrv); end
    checks++; if (rv_dat[0] !== 32'hAA) begin errors++; $display("FAIL single_rd_data got %h want aa", rv_dat[0]); end
    checks++; if (nwr !== 0) begin errors++; $display("FAIL single_rd_wr_low got %0d want 0", nwr); end
  endtask

  task automatic test_burst;
    run_txn(1'b1, 1'b1, 1'b1, 10'h040, 32'hA10);
    checks++; if (nack !== 4) begin errors++; $display("FAIL burst_wr_acks got %0d want 4", nack); end
    checks++; if (nwr !== 4) begin errors++; $display("FAIL burst_wr_strobe_cycles got %0d want 4", nwr); end
    checks++; if (!turn_ok) begin errors++; $display("FAIL burst_wr_turn got 0 want 1"); end
    for (int k = 0; k < 4; k++) begin
      checks++; if (beat_addr[k] !== 10'h040 + 10'(k)) begin errors++;
        $display("FAIL burst_wr_addr%0d got %h want %h", k, beat_addr[k], 10'h040 + 10'(k)); end
    end
    run_txn(1'b1, 1'b0, 1'b1, 10'h040, 32'h0);
    checks++; if (nack !== 4 || nrv !== 4) begin errors++; $display("FAIL burst_rd_counts got ack=%0d rv=%0d want 4 4", nack, nrv); end
    for (int k = 0; k < 4; k++) begin
      checks++; if (rv_dat[k] !== 32'hA10 + 32'(k)) begin errors++;
        $display("FAIL burst_rd_data%0d got %h want %h", k, rv_dat[k], 32'hA10 + 32'(k)); end
    end
  endtask

  task automatic test_wrap;
    logic [9:0] exp_a [4] = '{10'h3FE, 10'h3FF, 10'h000, 10'h001};
    run_txn(1'b1, 1'b1, 1'b1, 10'h3FE, 32'hC00);
    for (int k = 0; k < 4; k++) begin
      checks++; if (beat_addr[k] !== exp_a[k]) begin errors++;
        $display("FAIL wrap_addr%0d got %h want %h", k, beat_addr[k], exp_a[k]); end
    end
    run_txn(1'b1, 1'b0, 1'b1, 10'h3FE, 32'h0);
    for (int k = 0; k < 4; k++) begin
      checks++; if (rv_dat[k] !== 32'hC00 + 32'(k)) begin errors++;
        $display("FAIL wrap_rd_data%0d got %h want %h", k, rv_dat[k], 32'hC00 + 32'(k)); end
    end
  endtask

  // The last owner was requester 1, so round-robin starts with requester 0.
  task automatic test_arb;
    int got, exp;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      drive(1'b0, 1'b1, 1'b1, 1'b0, 10'h180 + 10'(i), 32'h500 + 32'(i));
      drive(1'b1, 1'b1, 1'b1, 1'b0, 10'h1C0 + 10'(i), 32'h600 + 32'(i));
      got = 9;
      for (int c = 0; c < 10 && got == 9; c++) begin
        @(negedge clk);
        if (ack0) got = 0;
        else if (ack1) got = 1;
      end
      req0 = 1'b0; req1 = 1'b0;
      repeat (2) @(negedge clk);
      exp = RR ? (i % 2) : 0;
      checks++; if (got !== exp) begin errors++;
        $display("FAIL arb_grant%0d got %0d want %0d", i, got, exp); end
    end
  endtask

  task automatic test_reset_mid;
    int n, stray;
    n = 0;
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b1, 1'b1, 10'h200, 32'hB00);
    for (int c = 0; c < 20 && n < 3; c++) begin
      @(negedge clk);
      if (ack0) begin
        n++;
        if (n < 3) begin @(posedge clk); #1; wdat0 = 32'hB00 + 32'(n); end
      end
    end
    checks++; if (n !== 3) begin errors++; $display("FAIL rstmid_reach_beat2 got %0d acks want 3", n); end
    rst = 1'b1;
    #1;
    checks++; if ({rd_, wr_, gnt0, ack0, dut.dat_oe} !== 5'b11000) begin errors++;
      $display("FAIL rstmid_immediate got %b want 11000", {rd_, wr_, gnt0, ack0, dut.dat_oe}); end
    req0 = 1'b0;
    stray = 0;
    repeat (2) begin @(negedge clk); if (ack0 || ack1) stray++; end
    rst = 1'b0;
    repeat (3) begin @(negedge clk); if (ack0 || ack1) stray++; end
    checks++; if (stray !== 0) begin errors++; $display("FAIL rstmid_no_ack got %0d want 0", stray); end
    run_txn(1'b0, 1'b0, 1'b0, 10'h200, 32'h0);
    checks++; if (nack !== 1 || rv_dat[0] !== 32'hB00) begin errors++;
      $display("FAIL rstmid_fresh_rd0 got ack=%0d dat=%h want 1 b00", nack, rv_dat[0]); end
    run_txn(1'b0, 1'b0, 1'b0, 10'h201, 32'h0);
    checks++; if (rv_dat[0] !== 32'hB01) begin errors++;
      $display("FAIL rstmid_fresh_rd1 got %h want b01", rv_dat[0]); end
  endtask

  task automatic test_back_to_back;
    bit seen;
    seen = 1'b0;
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 10'h300, 32'h11);
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clk);
      if (ack0) seen = 1'b1;
    end
    checks++; if (!seen) begin errors++; $display("FAIL b2b_first_ack got 0 want 1"); end
    req0 = 1'b0;
    drive(1'b1, 1'b1, 1'b1, 1'b0, 10'h301, 32'h22);
    @(negedge clk);
    checks++; if ({gnt0, gnt1, rd_, wr_, dut.dat_oe} !== 5'b00110) begin errors++;
      $display("FAIL b2b_turn got %b want 00110", {gnt0, gnt1, rd_, wr_, dut.dat_oe}); end
    @(negedge clk);
    checks++; if ({ack1, gnt1, wr_} !== 3'b110) begin errors++;
      $display("FAIL b2b_second_beat got %b want 110", {ack1, gnt1, wr_}); end
    checks++; if (addr !== 10'h301 || dat !== 32'h22) begin errors++;
      $display("FAIL b2b_second_bus got addr=%h dat=%h want 301 22", addr, dat); end
    req1 = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (mem[10'h300] !== 32'h11 || mem[10'h301] !== 32'h22) begin errors++;
      $display("FAIL b2b_mem got %h %h want 11 22", mem[10'h300], mem[10'h301]); end
  endtask

  initial begin
    test_reset;
    test_single;
    test_burst;
    test_wrap;
    test_arb;
    test_reset_mid;
    test_back_to_back;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
